// File: rtl/pll_reconfig_seq.sv
// PLL register-bus reconfiguration sequencer with PLLRST pulse and filtered lock.
// Optional readback verification of each write: define PLL_RECONFIG_VERIFY_EN.
module pll_reconfig_seq #(
  parameter int unsigned LOCK_FILT    = 64,
  parameter int unsigned LOCK_TIMEOUT = 50000,
  parameter int unsigned RST_CYCLES   = 16,
  parameter int unsigned ACK_TIMEOUT  = 255
) (
  input  logic       CLKI,
  input  logic       RST,
  input  logic       CFG_VALID,
  output logic       CFG_READY,
  input  logic [4:0] CFG_ADDR,
  input  logic [7:0] CFG_DATA,
  input  logic       CFG_LAST,
  output logic       PLLSTB,
  output logic       PLLWE,
  output logic [4:0] PLLADDR,
  output logic [7:0] PLLDATI,
  input  logic [7:0] PLLDATO,
  input  logic       PLLACK,
  output logic       PLLRST,
  input  logic       LOCK,
  output logic       CLK_STABLE,
  output logic       BUSY,
  output logic [1:0] ERR
);

  localparam int unsigned FW = $clog2(LOCK_FILT + 1);
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned RW = $clog2(RST_CYCLES + 1);
  localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [1:0] ERR_NONE = 2'b00;
  localparam logic [1:0] ERR_ACK  = 2'b01;
  localparam logic [1:0] ERR_LOCK = 2'b10;
`ifdef PLL_RECONFIG_VERIFY_EN
  localparam logic [1:0] ERR_RDBK = 2'b11;
`endif

  typedef enum logic [2:0] {
    S_WAIT_LOCK,
    S_IDLE,
    S_WR,
`ifdef PLL_RECONFIG_VERIFY_EN
    S_RD,
`endif
    S_NEXT,
    S_PRST,
    S_FAULT
  } state_e;

  state_e        state_q;
  logic          lock_s1_q, lock_s2_q;
  logic [FW-1:0] filt_q;
  logic [TW-1:0] tmo_q;
  logic [RW-1:0] rst_cnt_q;
  logic [AW-1:0] ack_cnt_q;
  logic          last_q;
  logic          cfg_ready_q, stb_q, we_q, pllrst_q, clk_stable_q, busy_q;
  logic [4:0]    addr_q;
  logic [7:0]    dati_q;
  logic [1:0]    err_q;

  assign CFG_READY  = cfg_ready_q;
  assign PLLSTB     = stb_q;
  assign PLLWE      = we_q;
  assign PLLADDR    = addr_q;
  assign PLLDATI    = dati_q;
  assign PLLRST     = pllrst_q;
  assign CLK_STABLE = clk_stable_q;
  assign BUSY       = busy_q;
  assign ERR        = err_q;

`ifndef PLL_RECONFIG_VERIFY_EN
  logic unused_dato;
  assign unused_dato = ^PLLDATO;
`endif

  always_ff @(posedge CLKI) begin
    if (RST) begin
      state_q      <= S_WAIT_LOCK;
      lock_s1_q    <= 1'b0;
      lock_s2_q    <= 1'b0;
      filt_q       <= '0;
      tmo_q        <= '0;
      rst_cnt_q    <= '0;
      ack_cnt_q    <= '0;
      last_q       <= 1'b0;
      cfg_ready_q  <= 1'b0;
      stb_q        <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      dati_q       <= '0;
      pllrst_q     <= 1'b0;
      clk_stable_q <= 1'b0;
      busy_q       <= 1'b1;
      err_q        <= ERR_NONE;
    end else begin
      lock_s1_q <= LOCK;
      lock_s2_q <= lock_s1_q;
      case (state_q)
        S_WAIT_LOCK: begin
          if (tmo_q != '1) tmo_q <= tmo_q + TW'(1);
          if (!lock_s2_q)        filt_q <= '0;
          else if (filt_q != '1) filt_q <= filt_q + FW'(1);
          // Lock success wins over a timeout landing on the same cycle
          if (lock_s2_q && (filt_q >= FW'(LOCK_FILT - 1))) begin
            state_q      <= S_IDLE;
            clk_stable_q <= 1'b1;
            cfg_ready_q  <= 1'b1;
            busy_q       <= 1'b0;
            filt_q       <= '0;
            tmo_q        <= '0;
          end else if (tmo_q >= TW'(LOCK_TIMEOUT - 1)) begin
            state_q     <= S_FAULT;
            err_q       <= ERR_LOCK;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            filt_q      <= '0;
            tmo_q       <= '0;
          end
        end

        S_IDLE, S_NEXT, S_FAULT: begin
          if (CFG_VALID && cfg_ready_q) begin
            state_q      <= S_WR;
            addr_q       <= CFG_ADDR;
            dati_q       <= CFG_DATA;
            last_q       <= CFG_LAST;
            cfg_ready_q  <= 1'b0;
            clk_stable_q <= 1'b0;
            busy_q       <= 1'b1;
            err_q        <= ERR_NONE;
            stb_q        <= 1'b1;
            we_q         <= 1'b1;
            ack_cnt_q    <= '0;
          end else if ((state_q == S_IDLE) && !lock_s2_q) begin
            state_q      <= S_WAIT_LOCK;
            clk_stable_q <= 1'b0;
            cfg_ready_q  <= 1'b0;
            busy_q       <= 1'b1;
            filt_q       <= '0;
            tmo_q        <= '0;
          end
        end

        S_WR: begin
          if (PLLACK) begin
            stb_q     <= 1'b0;
            we_q      <= 1'b0;
            ack_cnt_q <= '0;
`ifdef PLL_RECONFIG_VERIFY_EN
            state_q   <= S_RD;
`else
            if (last_q) begin
              state_q   <= S_PRST;
              pllrst_q  <= 1'b1;
              rst_cnt_q <= '0;
            end else begin
              state_q     <= S_NEXT;
              cfg_ready_q <= 1'b1;
            end
`endif
          end else if (ack_cnt_q >= AW'(ACK_TIMEOUT - 1)) begin
            state_q     <= S_FAULT;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            err_q       <= ERR_ACK;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            ack_cnt_q   <= '0;
          end else if (ack_cnt_q != '1) begin
            ack_cnt_q <= ack_cnt_q + AW'(1);
          end
        end

`ifdef PLL_RECONFIG_VERIFY_EN
        // Strobe drops for one cycle between the write and its readback
        S_RD: begin
          if (!stb_q) begin
            stb_q <= 1'b1;
            we_q  <= 1'b0;
          end else if (PLLACK) begin
            stb_q     <= 1'b0;
            ack_cnt_q <= '0;
            if (PLLDATO != dati_q) begin
              state_q     <= S_FAULT;
              err_q       <= ERR_RDBK;
              cfg_ready_q <= 1'b1;
              busy_q      <= 1'b0;
            end else if (last_q) begin
              state_q   <= S_PRST;
              pllrst_q  <= 1'b1;
              rst_cnt_q <= '0;
            end else begin
              state_q     <= S_NEXT;
              cfg_ready_q <= 1'b1;
            end
          end else if (ack_cnt_q >= AW'(ACK_TIMEOUT - 1)) begin
            state_q     <= S_FAULT;
            stb_q       <= 1'b0;
            err_q       <= ERR_ACK;
            cfg_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            ack_cnt_q   <= '0;
          end else if (ack_cnt_q != '1) begin
            ack_cnt_q <= ack_cnt_q + AW'(1);
          end
        end
`endif

        S_PRST: begin
          if (rst_cnt_q >= RW'(RST_CYCLES - 1)) begin
            state_q   <= S_WAIT_LOCK;
            pllrst_q  <= 1'b0;
            rst_cnt_q <= '0;
            filt_q    <= '0;
            tmo_q     <= '0;
          end else if (rst_cnt_q != '1) begin
            rst_cnt_q <= rst_cnt_q + RW'(1);
          end
        end

        default: state_q <= S_WAIT_LOCK;
      endcase
    end
  end

endmodule
